// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit: reset vector, FSM encodings, FIFO entry layout.
package fetch_unit_pkg;

  localparam logic [15:0] FETCH_RESET_VEC = 16'hFFFC;
  localparam int          FETCH_ENTRY_SZ  = 24;

  localparam logic [1:0] ST_VEC_LO   = 2'd0;
  localparam logic [1:0] ST_VEC_HI   = 2'd1;
  localparam logic [1:0] ST_VEC_LOAD = 2'd2;
  localparam logic [1:0] ST_RUN      = 2'd3;

  // Entry layout is {byte, pc}.
  function automatic logic [FETCH_ENTRY_SZ-1:0] pack_entry(input logic [7:0] b,
                                                           input logic [15:0] pc);
    return {b, pc};
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Small synchronous FIFO with a registered head so the output holds its last value when empty.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push_i,
  input  logic [FETCH_ENTRY_SZ-1:0] push_data_i,
  input  logic                      pop_i,
  input  logic                      flush_i,
  output logic [FETCH_ENTRY_SZ-1:0] head_data_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [FETCH_ENTRY_SZ-1:0] mem_q [DEPTH];
  logic [AW-1:0]             rd_ptr_q, wr_ptr_q, rd_next;
  logic [CW-1:0]             count_q;
  logic [FETCH_ENTRY_SZ-1:0] head_q, head_d;

  assign rd_next = rd_ptr_q + 1'b1;

  // The head register tracks whatever entry will sit at rd_ptr after this edge.
  always_comb begin
    head_d = head_q;
    if (pop_i) begin
      if (count_q > CW'(1)) head_d = mem_q[rd_next];
      else if (push_i)      head_d = push_data_i;
    end else if (push_i && (count_q == '0)) begin
      head_d = push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_next;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      head_q <= head_d;
    end
  end

  assign head_data_o = head_q;
  assign count_o     = count_q;
  assign empty_o     = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: loads the reset vector, then streams sequential bytes from synchronous memory
// through a small FIFO, restarting on redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] RESET_VEC = FETCH_RESET_VEC
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] addr_i,
  input  logic [7:0]  din_i,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [7:0]  instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [1:0]                state_q, state_d;
  logic [7:0]                vec_lo_q;
  logic [15:0]               fetch_pc_q, fetch_pc_d;
  logic                      inflight_q;
  logic [15:0]               inflight_pc_q;
  logic                      run, issue, push, pop, flush, fifo_empty;
  logic [CW-1:0]             fifo_count;
  logic [FETCH_ENTRY_SZ-1:0] head;

  assign run = (state_q == ST_RUN);
  // Each in-flight byte already owns a FIFO slot, so the FIFO can never overflow.
  assign issue = run && !redirect &&
                 (({1'b0, fifo_count} + {{CW{1'b0}}, inflight_q}) < DEPTH_C);
  assign push  = inflight_q && !redirect;
  assign pop   = instr_valid && instr_ready && !redirect;
  assign flush = run && redirect;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_i     = RESET_VEC;
    case (state_q)
      ST_VEC_LO: state_d = ST_VEC_HI;
      ST_VEC_HI: begin
        addr_i  = RESET_VEC + 16'd1;
        state_d = ST_VEC_LOAD;
      end
      ST_VEC_LOAD: begin
        addr_i     = RESET_VEC + 16'd1;
        fetch_pc_d = {din_i, vec_lo_q};
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        addr_i = fetch_pc_q;
        if (redirect)   fetch_pc_d = redirect_pc;
        else if (issue) fetch_pc_d = fetch_pc_q + 16'd1;
      end
      default: state_d = ST_VEC_LO;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_VEC_LO;
      vec_lo_q      <= '0;
      fetch_pc_q    <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= issue;
      if (state_q == ST_VEC_HI) vec_lo_q <= din_i;
      if (issue) inflight_pc_q <= fetch_pc_q;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst),
    .push_i     (push),
    .push_data_i(pack_entry(din_i, inflight_pc_q)),
    .pop_i      (pop),
    .flush_i    (flush),
    .head_data_o(head),
    .count_o    (fifo_count),
    .empty_o    (fifo_empty)
  );

  assign instr       = head[23:16];
  assign instr_pc    = head[15:0];
  assign instr_valid = !fifo_empty;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized ready/redirect traffic
// checked against an in-order byte-stream reference model.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr_i;
  logic [7:0]  din_i;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [7:0]  instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;

  always #5 clk = ~clk;

  logic [7:0] mem [65536];
  always @(posedge clk) din_i <= mem[addr_i];

  fetch_unit #(.DEPTH(DEPTH), .RESET_VEC(16'hFFFC)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr_i     (addr_i),
    .din_i      (din_i),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] exp_pc = '0;
  bit          running = 1'b0;
  int          redir_age = 99;
  int          n_acc = 0;
  int          n0;
  logic [15:0] vec2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, score any accepted byte, then advance to #1 after the next edge.
  task automatic cyc(input bit rdy, input bit redir, input logic [15:0] rpc);
    logic [15:0] outstanding;
    instr_ready = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    if (running) begin
      outstanding = addr_i - exp_pc;
      chk("outstanding_le_depth", {31'd0, outstanding <= 16'(DEPTH)}, 32'd1);
      if (instr_valid && rdy && !redir) begin
        chk("instr_pc", instr_pc, exp_pc);
        chk("instr_byte", instr, mem[exp_pc]);
        exp_pc = exp_pc + 16'd1;
        n_acc++;
      end
      if (redir) begin
        exp_pc    = rpc;
        redir_age = 0;
      end
    end
    @(posedge clk);
    #1;
    if (redir_age < 99) redir_age++;
    if (redir_age == 1 || redir_age == 2) chk("valid_low_after_redirect", instr_valid, 0);
  endtask

  task automatic reset_release(input logic [15:0] vec);
    mem[16'hFFFC] = vec[7:0];
    mem[16'hFFFD] = vec[15:8];
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("vec_lo_addr", addr_i, 16'hFFFC);
    chk("vec_lo_valid", instr_valid, 0);
    cyc(1, 0, 0);
    chk("vec_hi_addr", addr_i, 16'hFFFD);
    cyc(1, 0, 0);
    chk("vec_load_addr", addr_i, 16'hFFFD);
    chk("vec_load_valid", instr_valid, 0);
    cyc(1, 0, 0);
    chk("run_addr", addr_i, vec);
    exp_pc  = vec;
    running = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    rst = 1'b1;
    #1 rst = 1'b0;
    instr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 8'h00);
    chk("rst_instr_pc", instr_pc, 16'h0000);
    chk("rst_addr", addr_i, 16'hFFFC);

    reset_release(16'h8000);

    // Backpressure: nothing accepted, four bytes buffered, issue stalls at 8004.
    cyc(0, 0, 0);
    chk("first_valid_latency_1", instr_valid, 0);
    cyc(0, 0, 0);
    chk("first_valid_latency_2", instr_valid, 1);
    chk("first_pc", instr_pc, 16'h8000);
    repeat (6) cyc(0, 0, 0);
    chk("stall_addr", addr_i, 16'h8004);
    chk("stall_valid", instr_valid, 1);
    chk("stall_head_pc", instr_pc, 16'h8000);

    // Release; settles at two buffered plus one in flight, one byte per cycle.
    n0 = n_acc;
    repeat (3) cyc(1, 0, 0);
    for (int k = 0; k < 10; k++) begin
      chk("steady_valid", instr_valid, 1);
      chk("steady_gap", addr_i - instr_pc, 16'd3);
      cyc(1, 0, 0);
    end
    chk("steady_rate", n_acc - n0, 13);

    for (int k = 0; k < 50 && addr_i != 16'h8010; k++) cyc(1, 0, 0);
    chk("reach_8010", addr_i, 16'h8010);
    chk("nonempty_before_redirect", instr_valid, 1);
    cyc(1, 1, 16'hC000);
    chk("redirect_addr", addr_i, 16'hC000);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("redirect_valid_t3", instr_valid, 1);
    chk("redirect_pc_t3", instr_pc, 16'hC000);
    repeat (5) cyc(1, 0, 0);

    // Address wrap through FFFF.
    cyc(1, 1, 16'hFFFE);
    n0 = n_acc;
    repeat (8) cyc(1, 0, 0);
    chk("wrap_acc", n_acc - n0, 6);
    chk("wrap_head", instr_pc, 16'h0004);

    for (int k = 0; k < 1500; k++)
      cyc(($urandom % 4) != 0, ($urandom % 32) == 0, 16'($urandom));

    // Async reset with three bytes buffered.
    cyc(0, 1, 16'h4000);
    repeat (4) cyc(0, 0, 0);
    chk("pre_reset_pc", instr_pc, 16'h4000);
    chk("pre_reset_addr", addr_i, 16'h4004);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid", instr_valid, 0);
    chk("async_rst_addr", addr_i, 16'hFFFC);
    running   = 1'b0;
    redir_age = 99;
    vec2 = 16'($urandom);
    reset_release(vec2);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("post_reset_valid", instr_valid, 1);
    chk("post_reset_pc", instr_pc, vec2);
    repeat (20) cyc(1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
